flopenrc_pipe: RTL
==================

// Module: flopenrc_pipe
// PURPOSE
//  Parametrised elastic pipeline register: DEPTH stages of WIDTH-bit data, each stage with a valid bit.
//  Generalises the single enable/clear flop to a multi-stage valid/ready chain.
//  Supports per-stage backpressure, bubble collapsing, synchronous flush and occupancy reporting.
//  Sits between CPU pipeline units (e.g. fetch->decode, execute->writeback) to absorb stalls and flushes.
// PARAMETERS
//  WIDTH  8  data width in bits (>=1)
//  DEPTH  2  number of register stages (>=1)
//  CW     $clog2(DEPTH+1)  derived width of count; not to be overridden
// PORTS
//  clk        in   1      clock; all state changes on rising edge
//  reset      in   1      asynchronous, active-low reset
//  clear      in   1      synchronous flush, active-high, priority over all transfers
//  in_valid   in   1      upstream beat offered
//  in_ready   out  1      pipeline accepts beat this cycle
//  in_data    in   WIDTH  upstream data
//  out_valid  out  1      last stage holds a valid beat
//  out_ready  in   1      downstream accepts beat this cycle
//  out_data   out  WIDTH  last-stage data
//  count      out  CW     number of valid stages, 0..DEPTH
// BEHAVIOUR
//  - Stages are indexed 0 (input side) to DEPTH-1 (output side); each stage has v[k] and d[k].
//  - Reset (reset==0), asynchronous and immediate with no clock edge needed:
//    all v[k]=0, all d[k]=0, count=0. Outputs become out_valid=0, out_data=0, in_ready=1 (clear=0).
//  - Ready chain, combinational: r[DEPTH]=out_ready and r[k]=!v[k] || r[k+1]. in_ready=r[0] && !clear.
//    A combinational path out_ready->in_ready is allowed and intended.
//  - On each edge with clear==0, for every k with r[k]==1:
//    v[k]<=src_v and, if src_v, d[k]<=src_d. The source is stage k-1, or in_valid/in_data for k=0.
//    If src_v==0, d[k] holds its previous value.
//  - A stage with r[k]==0 holds both v[k] and d[k].
//  - Transfers: input when in_valid && in_ready; output when out_valid && out_ready.
//    Beats are never duplicated, dropped or reordered.
//  - Bubble collapsing: a beat advances whenever the next stage is empty, even if out_ready=0.
//    The pipeline fills completely before asserting backpressure.
//  - Latency: with out_ready held 1, a beat accepted at edge N is on out_data after edge N+DEPTH-1.
//    It is visible DEPTH-1 cycles after acceptance. DEPTH=1 gives 1-cycle register latency.
//  - Throughput: 1 beat/cycle sustained, including DEPTH=1 when full and out_ready=1.
//  - out_valid=v[DEPTH-1] && !clear. out_data=d[DEPTH-1].
//  - clear==1 at an edge: all v[k]<=0, all d[k]<=0, count<=0.
//    in_ready and out_valid are forced 0 during that cycle, so no handshake completes.
//  - Clear and reset together: reset wins.
//  - Clearing an empty pipe is legal and has no other effect.
//  - count is registered and always equals popcount(v) after each edge.
//    Simultaneous input and output transfers leave count unchanged.
//  - in_data and in_valid are X-tolerant when not transferring; X must never reach a stage with v=1.
// TESTING (WIDTH=8, DEPTH=3 unless noted)
//  1. Drive reset=0 with in_valid=1, in_data=A5, clock running.
//     -> out_valid=0, out_data=00, count=0 throughout. After reset=1: in_ready=1.
//  2. out_ready=1; push 01,02,03 back-to-back from edge 1.
//     -> out_data=01 with out_valid after edge 3, then 02 and 03 on consecutive cycles. count peaks at 3.
//  3. out_ready=0; offer 11..15.
//     -> only 11,12,13 accepted; in_ready=0 once count=3; count stays 3.
//     Then out_ready=1 -> output 11,12,13,14,15 in order, no gaps once refilled.
//  4. out_ready=0; push single beat 7E.
//     -> it reaches stage 2 after 3 edges; out_valid=1, count=1, in_ready stays 1.
//  5. Full pipe (count=3), in_valid=1, assert clear for one edge.
//     -> in_ready=0 and out_valid=0 in that cycle; next cycle count=0, out_data=00; offered beat not accepted.
//  6. Assert reset=0 mid-stream between clock edges.
//     -> out_valid=0, out_data=00, count=0 immediately. Resume after release with no stale beats.

Source files
------------

// File: rtl/flopenrc_pipe.sv
// Elastic DEPTH-stage valid/ready pipeline register with
// bubble collapsing, synchronous flush and occupancy count.
module flopenrc_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH:0]   r;
  logic [CW-1:0]    count_q, count_d;

  // Ready ripples from the output back towards the input.
  always_comb begin
    logic rr;
    rr       = out_ready;
    r        = '0;
    r[DEPTH] = rr;
    for (int k = DEPTH-1; k >= 0; k--) begin
      rr   = !v_q[k] || rr;
      r[k] = rr;
    end
  end

  always_comb begin
    v_d     = v_q;
    d_d     = d_q;
    count_d = '0;
    if (clear) begin
      v_d = '0;
      for (int k = 0; k < DEPTH; k++)
        d_d[k] = '0;
    end else begin
      if (r[0]) begin
        v_d[0] = in_valid;
        if (in_valid)
          d_d[0] = in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (r[k]) begin
          v_d[k] = v_q[k-1];
          if (v_q[k-1])
            d_d[k] = d_q[k-1];
        end
      end
    end
    for (int k = 0; k < DEPTH; k++)
      count_d = count_d + CW'(v_d[k]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++)
        d_q[k] <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int k = 0; k < DEPTH; k++)
        d_q[k] <= d_d[k];
    end
  end

  assign in_ready  = r[0] && !clear;
  assign out_valid = v_q[DEPTH-1] && !clear;
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;

endmodule
